// File: rtl/scan_chain_ctrl.sv
// Scan-test controller for a MUX-D scan chain: buffers one pattern, shifts it in,
// pulses a capture cycle and compacts the chain's scan-out into a 16-bit MISR.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN = 64,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic        pat_valid,
   input  logic        pat_bit,
   input  logic        pat_last,
   output logic        pat_ready,
   output logic        SE,
   output logic        SI,
   input  logic        SO,
   output logic        test_mode,
   output logic        busy,
   output logic        done,
   output logic [15:0] sig,
   output logic [2:0]  dbg_state
);

   // Handshake: a pattern bit transfers on a rising edge where pat_valid & pat_ready.
   // pat_ready is decoded from state only, and upstream may hold pat_valid low indefinitely.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_SHIFT   = 3'd2,
      S_CAPTURE = 3'd3,
      S_FLUSH   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

   state_t               r_state;
   state_t               w_next;
   logic [CNT_W-1:0]     r_cnt;
   logic [CHAIN_LEN-1:0] r_buf;
   logic                 r_last_f;
   logic                 r_compact_en;
   logic [15:0]          r_sig;

   logic                 w_accept;
   logic                 w_cnt_end;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [15:0]          w_misr;

   assign w_accept  = (r_state == S_LOAD) && pat_valid;
   assign w_cnt_end = (r_cnt == LP_CNT_LAST);
   assign w_cnt_nxt = w_cnt_end ? '0 : (r_cnt + LP_CNT_ONE);
   assign w_misr    = ({r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000)) ^ {15'd0, SO};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = S_LOAD;
         S_LOAD:    if (w_accept && w_cnt_end) w_next = S_SHIFT;
         S_SHIFT:   if (w_cnt_end) w_next = S_CAPTURE;
         S_CAPTURE: w_next = r_last_f ? S_FLUSH : S_LOAD;
         S_FLUSH:   if (w_cnt_end) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_buf        <= '0;
         r_last_f     <= 1'b0;
         r_compact_en <= 1'b0;
         r_sig        <= 16'h0000;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               r_cnt        <= '0;
               r_compact_en <= 1'b0;
               // The previous signature stays readable until a new session starts.
               if (start) begin
                  r_sig    <= 16'h0000;
                  r_last_f <= 1'b0;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_buf <= {pat_bit, r_buf[CHAIN_LEN-1:1]};
                  r_cnt <= w_cnt_nxt;
                  if (w_cnt_end) r_last_f <= pat_last;
               end
            end
            S_SHIFT: begin
               r_buf <= {1'b0, r_buf[CHAIN_LEN-1:1]};
               r_cnt <= w_cnt_nxt;
               if (r_compact_en) r_sig <= w_misr;
            end
            S_CAPTURE: r_compact_en <= 1'b1;
            S_FLUSH: begin
               r_cnt <= w_cnt_nxt;
               if (r_compact_en) r_sig <= w_misr;
            end
            default: ;
         endcase
      end
   end

   assign pat_ready = (r_state == S_LOAD);
   assign SE        = (r_state == S_SHIFT) || (r_state == S_FLUSH);
   assign SI        = (r_state == S_SHIFT) && r_buf[0];
   assign busy      = (r_state != S_IDLE);
   assign test_mode = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign sig       = r_sig;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with CHAIN_LEN=4: directed sessions plus randomized
// sessions checked against a cycle-schedule and MISR reference model.
module tb_scan_chain_ctrl;
   localparam int N = 4;
   localparam int P = 2 * N + 1;
   localparam logic [N-1:0] FUNC_D = 4'b0110;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, pat_valid, pat_bit, pat_last, so_drv, chain_mode, so_rand;
   logic pat_ready, se, si, test_mode, busy, done;
   logic [15:0] sig;
   logic [2:0] dbg_state;
   logic [N-1:0] chain;
   logic w_so;

   assign w_so = chain_mode ? chain[N-1] : so_drv;

   // Behavioural MUX2X1+DFFPOSX1 chain with functional inputs tied to FUNC_D.
   always @(posedge clk) chain <= se ? {chain[N-2:0], si} : FUNC_D;

   scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
      .CLK(clk), .RST(rst), .start(start), .pat_valid(pat_valid), .pat_bit(pat_bit),
      .pat_last(pat_last), .pat_ready(pat_ready), .SE(se), .SI(si), .SO(w_so),
      .test_mode(test_mode), .busy(busy), .done(done), .sig(sig), .dbg_state(dbg_state)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int accepted = 0;
   int stall_at = -1;
   int stall_left = 0;
   logic bq[$];
   logic lq[$];
   logic se_a[0:255], si_a[0:255], rdy_a[0:255], so_a[0:255];
   logic [2:0] st_a[0:255];
   logic [N-1:0] pat_v[0:3];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] fold(input logic [15:0] s, input logic b);
      return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {15'd0, b};
   endfunction

   // 0 LOAD, 1 SHIFT, 2 CAPTURE, 3 FLUSH, 4 DONE for cycle t of an unstalled session.
   function automatic int phase_of(input int t, input int np);
      int r;
      r = (t - 1) % P;
      if (t <= np * P) begin
         if (r < N) return 0;
         if (r < 2 * N) return 1;
         return 2;
      end
      if (t <= np * P + N) return 3;
      return 4;
   endfunction

   task automatic push_pat(input logic [N-1:0] p, input logic [N-1:0] lastm);
      for (int j = N - 1; j >= 0; j--) begin
         bq.push_back(p[j]);
         lq.push_back(lastm[j]);
      end
   endtask

   task automatic tick();
      int c;
      logic acc;
      c = (cyc > 255) ? 255 : cyc;
      se_a[c] = se; si_a[c] = si; rdy_a[c] = pat_ready; st_a[c] = dbg_state;
      if (so_rand) so_drv = 1'($urandom_range(0, 1));
      so_a[c] = so_drv;
      if (pat_ready === 1'b1 && stall_left > 0 && accepted == stall_at) begin
         pat_valid = 1'b0;
         stall_left--;
      end else if (bq.size() > 0) begin
         pat_valid = 1'b1; pat_bit = bq[0]; pat_last = lq[0];
      end else begin
         pat_valid = 1'b0; pat_bit = 1'b0; pat_last = 1'b0;
      end
      acc = (pat_ready === 1'b1) && pat_valid;
      @(posedge clk); #1;
      if (acc && bq.size() > 0) begin
         void'(bq.pop_front());
         void'(lq.pop_front());
         accepted++;
      end
      cyc++;
   endtask

   task automatic start_session();
      accepted = 0;
      cyc = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("sig_cleared_t1", sig, 16'h0000);
      chk("test_mode_t1", test_mode, 1'b1);
      chk("busy_t1", busy, 1'b1);
   endtask

   task automatic wait_done(output int dcyc);
      dcyc = -1;
      for (int i = 0; i < 400 && done !== 1'b1; i++) tick();
      if (done === 1'b1) dcyc = cyc;
   endtask

   task automatic check_session(input int np, input int dcyc, input bit do_sig);
      int exp_done, ph, pi, r;
      logic [15:0] s;
      exp_done = np * P + N + 1;
      s = 16'h0000;
      chk("done_cycle", dcyc, exp_done);
      if (dcyc == exp_done) begin
         for (int t = 1; t < exp_done; t++) begin
            ph = phase_of(t, np);
            pi = (t - 1) / P;
            r  = (t - 1) % P;
            chk($sformatf("se_t%0d", t), se_a[t], (ph == 1 || ph == 3));
            chk($sformatf("ready_t%0d", t), rdy_a[t], (ph == 0));
            chk($sformatf("si_t%0d", t), si_a[t], (ph == 1) ? pat_v[pi][N-1-(r-N)] : 1'b0);
            if ((ph == 1 && pi >= 1) || ph == 3) s = fold(s, so_a[t]);
         end
         if (do_sig) chk("sig_model", sig, s);
      end
   endtask

   task automatic finish_session(input logic [15:0] exp_sig);
      chk("done_pulse", done, 1'b1);
      tick();
      chk("done_cleared", done, 1'b0);
      chk("busy_idle", busy, 1'b0);
      chk("test_mode_idle", test_mode, 1'b0);
      chk("sig_hold_idle", sig, exp_sig);
   endtask

   initial begin
      int d, np, dones;
      logic [15:0] s;
      rst = 1'b1; start = 1'b0; pat_valid = 1'b0; pat_bit = 1'b0; pat_last = 1'b0;
      so_drv = 1'b0; so_rand = 1'b0; chain_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_se", se, 1'b0);        chk("rst_si", si, 1'b0);
      chk("rst_ready", pat_ready, 1'b0); chk("rst_test_mode", test_mode, 1'b0);
      chk("rst_busy", busy, 1'b0);    chk("rst_done", done, 1'b0);
      chk("rst_sig", sig, 16'h0000);  chk("rst_state", dbg_state, ST_IDLE);
      rst = 1'b0;
      tick();

      // Single pattern 1011, SO tied high.
      so_drv = 1'b1;
      pat_v[0] = 4'b1011;
      push_pat(4'b1011, 4'b0001);
      start_session();
      wait_done(d);
      check_session(1, d, 1'b1);
      chk("s1_sig", sig, 16'h000F);
      finish_session(16'h000F);
      tick();
      chk("s1_sig_hold2", sig, 16'h000F);

      // Two patterns, stray pat_last on bit 2, start pulsed during the second SHIFT.
      pat_v[0] = 4'b0110; pat_v[1] = 4'b1100;
      push_pat(pat_v[0], 4'b0100);
      push_pat(pat_v[1], 4'b0001);
      start_session();
      while (cyc < 15) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(d);
      check_session(2, d, 1'b1);
      chk("s2_sig", sig, 16'h00FF);
      finish_session(16'h00FF);

      // LOAD stall of 3 cycles after the second accepted bit.
      pat_v[0] = 4'b1001;
      push_pat(pat_v[0], 4'b0001);
      stall_at = 2; stall_left = 3;
      start_session();
      wait_done(d);
      chk("stall_done_cycle", d, 17);
      for (int t = 3; t <= 5; t++) begin
         chk($sformatf("stall_ready_t%0d", t), rdy_a[t], 1'b1);
         chk($sformatf("stall_se_t%0d", t), se_a[t], 1'b0);
         chk($sformatf("stall_state_t%0d", t), st_a[t], ST_LOAD);
      end
      chk("stall_sig", sig, 16'h000F);
      finish_session(16'h000F);
      stall_at = -1; stall_left = 0;

      // Reset asserted during FLUSH, then a clean rerun of the single-pattern case.
      pat_v[0] = 4'b1011;
      push_pat(pat_v[0], 4'b0001);
      start_session();
      while (cyc < 11) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_state", dbg_state, ST_IDLE);
      chk("mid_rst_se", se, 1'b0);
      chk("mid_rst_test_mode", test_mode, 1'b0);
      chk("mid_rst_sig", sig, 16'h0000);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) dones++;
         tick();
      end
      chk("mid_rst_no_done", dones, 0);
      push_pat(pat_v[0], 4'b0001);
      start_session();
      wait_done(d);
      check_session(1, d, 1'b1);
      chk("rerun_sig", sig, 16'h000F);
      finish_session(16'h000F);

      // Randomized sessions with random SO and stray pat_last on non-final bits.
      so_rand = 1'b1;
      for (int k = 0; k < 6; k++) begin
         np = $urandom_range(1, 3);
         for (int i = 0; i < np; i++) begin
            pat_v[i] = N'($urandom_range(0, 15));
            push_pat(pat_v[i], {3'($urandom_range(0, 7)), (i == np - 1) ? 1'b1 : 1'b0});
         end
         start_session();
         wait_done(d);
         check_session(np, d, 1'b1);
         s = sig;
         finish_session(s);
      end
      so_rand = 1'b0;

      // Chain model: every compacted unload returns the captured functional word.
      chain_mode = 1'b1;
      for (int k = 0; k < 3; k++) begin
         np = $urandom_range(1, 3);
         for (int i = 0; i < np; i++) begin
            pat_v[i] = N'($urandom_range(0, 15));
            push_pat(pat_v[i], (i == np - 1) ? 4'b0001 : 4'b0000);
         end
         start_session();
         wait_done(d);
         check_session(np, d, 1'b0);
         s = 16'h0000;
         for (int i = 0; i < np; i++)
            for (int j = N - 1; j >= 0; j--) s = fold(s, FUNC_D[j]);
         chk($sformatf("chain_sig_np%0d", np), sig, s);
         finish_session(s);
      end
      chain_mode = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
